// File: rtl/axi_rule_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_rule_loader_if
// Description : AXI-Lite bundle used by the rule-table loader. The master
//               modport drives AW/W/AR and the B/R ready strobes. The slave
//               modport drives the ready strobes for AW/W/AR and the B/R
//               responses.
// Ports       : awaddr/awvalid/awready, wdata/wstrb/wvalid/wready,
//               bresp/bvalid/bready, araddr/arvalid/arready,
//               rdata/rresp/rvalid/rready
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_rule_loader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axi_rule_loader.sv
`default_nettype none
// ============================================================================
// Module      : axi_rule_loader
// Description : Walks a table of N_ENTRIES (address, data) pairs and writes
//               every enabled entry over AXI-Lite, optionally reading it back
//               to confirm the value. Stops on the first bad response or
//               readback mismatch and reports the failing index.
// Ports       : s_axi_aclk, s_axi_aresetn (async, active-low)
//               start_i, verify_en_i, entry_en_i, entry_addr_i, entry_data_i
//               busy_o, done_o, err_o, err_idx_o
//               m_axi (axi_rule_loader_if.master)
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rule_loader #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int N_ENTRIES          = 8
) (
    input  wire logic                                                s_axi_aclk,
    input  wire logic                                                s_axi_aresetn,
    input  wire logic                                                start_i,
    input  wire logic                                                verify_en_i,
    input  wire logic [N_ENTRIES-1:0]                                entry_en_i,
    input  wire logic [N_ENTRIES-1:0][C_M_AXI_ADDR_WIDTH-1:0]        entry_addr_i,
    input  wire logic [N_ENTRIES-1:0][C_M_AXI_DATA_WIDTH-1:0]        entry_data_i,
    output logic                                                     busy_o,
    output logic                                                     done_o,
    output logic                                                     err_o,
    output logic [$clog2(N_ENTRIES)-1:0]                             err_idx_o,
    axi_rule_loader_if.master                                        m_axi
);
    localparam int IDX_W  = $clog2(N_ENTRIES);
    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
    // Index is one bit wider than an entry select so it can reach N_ENTRIES.
    localparam logic [IDX_W:0] C_END_IDX = (IDX_W+1)'(N_ENTRIES);
    localparam logic [IDX_W:0] C_IDX_ONE = (IDX_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_NEXT    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t                          state_q,   state_d;
    logic [IDX_W:0]                  idx_q,     idx_d;
    logic                            verify_q,  verify_d;
    logic                            err_q,     err_d;
    logic [IDX_W-1:0]                err_idx_q, err_idx_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q,  wvalid_d;
    logic                            arvalid_q, arvalid_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q,  awaddr_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_q,  araddr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q,   wdata_d;
    logic [STRB_W-1:0]               wstrb_q,   wstrb_d;

    // Entry selected by the low index bits; only consulted while idx_q < N.
    logic [IDX_W-1:0]                w_idx_lo;
    logic [IDX_W:0]                  w_idx_inc;
    logic                            w_sel_en;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   w_sel_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]   w_sel_data;

    assign w_idx_lo   = idx_q[IDX_W-1:0];
    assign w_idx_inc  = idx_q + C_IDX_ONE;
    assign w_sel_en   = entry_en_i[w_idx_lo];
    assign w_sel_addr = entry_addr_i[w_idx_lo];
    assign w_sel_data = entry_data_i[w_idx_lo];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        verify_d  = verify_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    verify_d  = verify_en_i;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    idx_d     = '0;
                    state_d   = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == C_END_IDX) begin
                    state_d = S_DONE;
                end else if (w_sel_en) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = w_sel_addr;
                    wdata_d   = w_sel_data;
                    wstrb_d   = '1;
                    state_d   = S_WR_REQ;
                end else begin
                    idx_d = w_idx_inc;
                end
            end
            S_WR_REQ: begin
                // AW and W retire independently; leave once neither is pending.
                awvalid_d = awvalid_q & ~m_axi.awready;
                wvalid_d  = wvalid_q & ~m_axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (m_axi.bvalid) begin
                    if (m_axi.bresp != 2'b00) begin
                        err_d     = 1'b1;
                        err_idx_d = w_idx_lo;
                        state_d   = S_DONE;
                    end else if (verify_q) begin
                        arvalid_d = 1'b1;
                        araddr_d  = w_sel_addr;
                        state_d   = S_RD_REQ;
                    end else begin
                        idx_d   = w_idx_inc;
                        state_d = S_NEXT;
                    end
                end
            end
            S_RD_REQ: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                if (m_axi.rvalid) begin
                    if ((m_axi.rresp != 2'b00) || (m_axi.rdata != w_sel_data)) begin
                        err_d     = 1'b1;
                        err_idx_d = w_idx_lo;
                        state_d   = S_DONE;
                    end else begin
                        idx_d   = w_idx_inc;
                        state_d = S_NEXT;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            verify_q  <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            verify_q  <= verify_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign err_o         = err_q;
    assign err_idx_o     = err_idx_q;

    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = (state_q == S_WR_RESP);
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = (state_q == S_RD_RESP);
endmodule
`default_nettype wire

// File: tb/tb_axi_rule_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rule_loader
// Description : Directed self-checking bench for axi_rule_loader with a
//               configurable AXI-Lite slave (per-channel ready latency,
//               programmable BRESP, one corruptible readback address).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rule_loader;
    logic            clk = 1'b0;
    logic            rstn;
    logic            start;
    logic            verify;
    logic [7:0]      en;
    logic [7:0][31:0] addr_t;
    logic [7:0][31:0] data_t;
    logic            busy, done, err;
    logic [2:0]      err_idx;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    // Slave configuration
    int          aw_lat = 0;
    int          w_lat  = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [31:0] corrupt_addr = 32'hFFFF_FFFF;

    // Transaction log entry: {kind, addr, data}
    logic [71:0] log_q[$];
    logic [31:0] mem [logic [31:0]];

    localparam logic [7:0] K_W = 8'h57;
    localparam logic [7:0] K_R = 8'h52;

    always #5 clk = ~clk;

    axi_rule_loader_if #(.ADDR_W(32), .DATA_W(32)) m_axi_if ();

    axi_rule_loader #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .N_ENTRIES(8)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rstn),
        .start_i      (start),
        .verify_en_i  (verify),
        .entry_en_i   (en),
        .entry_addr_i (addr_t),
        .entry_data_i (data_t),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .err_idx_o    (err_idx),
        .m_axi        (m_axi_if)
    );

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Slave: all decisions at the falling edge; a ready raised here handshakes
    // at the next rising edge. Responses go out one cycle after the request.
    logic        aw_got, w_got, b_pend, r_pend;
    logic [31:0] cap_addr, cap_data, r_data_pend;
    int          aw_cnt, w_cnt;
    initial begin
        m_axi_if.awready = 1'b0; m_axi_if.wready = 1'b0; m_axi_if.arready = 1'b0;
        m_axi_if.bvalid = 1'b0;  m_axi_if.bresp = 2'b00;
        m_axi_if.rvalid = 1'b0;  m_axi_if.rresp = 2'b00; m_axi_if.rdata = '0;
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
        cap_addr = '0; cap_data = '0; r_data_pend = '0; aw_cnt = 0; w_cnt = 0;
        forever begin
            @(negedge clk);
            m_axi_if.bvalid  = 1'b0;
            m_axi_if.rvalid  = 1'b0;
            m_axi_if.arready = 1'b0;
            if (b_pend) begin
                m_axi_if.bvalid = 1'b1; m_axi_if.bresp = bresp_cfg; b_pend = 1'b0;
            end
            if (r_pend) begin
                m_axi_if.rvalid = 1'b1; m_axi_if.rdata = r_data_pend;
                m_axi_if.rresp = 2'b00; r_pend = 1'b0;
            end
            if (m_axi_if.awvalid === 1'b1 && !aw_got) begin
                if (aw_cnt >= aw_lat) begin
                    m_axi_if.awready = 1'b1; aw_got = 1'b1; cap_addr = m_axi_if.awaddr; aw_cnt = 0;
                end else begin
                    m_axi_if.awready = 1'b0; aw_cnt++;
                end
            end else begin
                m_axi_if.awready = 1'b0;
                if (m_axi_if.awvalid !== 1'b1) aw_cnt = 0;
            end
            if (m_axi_if.wvalid === 1'b1 && !w_got) begin
                if (w_cnt >= w_lat) begin
                    m_axi_if.wready = 1'b1; w_got = 1'b1; cap_data = m_axi_if.wdata; w_cnt = 0;
                end else begin
                    m_axi_if.wready = 1'b0; w_cnt++;
                end
            end else begin
                m_axi_if.wready = 1'b0;
                if (m_axi_if.wvalid !== 1'b1) w_cnt = 0;
            end
            if (aw_got && w_got) begin
                log_q.push_back({K_W, cap_addr, cap_data});
                mem[cap_addr] = cap_data;
                aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
            end
            if (m_axi_if.arvalid === 1'b1) begin
                m_axi_if.arready = 1'b1;
                if (m_axi_if.araddr == corrupt_addr) r_data_pend = 32'hDEAD_BEEF;
                else if (mem.exists(m_axi_if.araddr)) r_data_pend = mem[m_axi_if.araddr];
                else r_data_pend = '0;
                log_q.push_back({K_R, m_axi_if.araddr, r_data_pend});
                r_pend = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] mk(input logic [7:0] k, input logic [31:0] a, input logic [31:0] d);
        return {k, a, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start high across exactly one rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        chk("done_seen", {71'd0, done}, 72'd1);
    endtask

    task automatic wait_awvalid();
        int n;
        n = 0;
        while (m_axi_if.awvalid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("awvalid_seen", {71'd0, m_axi_if.awvalid}, 72'd1);
    endtask

    int cyc;
    int dc0;

    initial begin
        rstn = 1'b0; start = 1'b0; verify = 1'b0; en = '0;
        for (int i = 0; i < 8; i++) begin
            addr_t[i] = 32'h20 + 32'(4 * i);
            data_t[i] = 32'hA000 + 32'(i);
        end
        addr_t[0] = 32'h00; data_t[0] = 32'h1000;
        addr_t[1] = 32'h04; data_t[1] = 32'h1FFF;
        addr_t[2] = 32'h08; data_t[2] = 32'h0001;
        addr_t[7] = 32'h1C; data_t[7] = 32'hCAFE_0007;
        tick(3);

        // Reset values
        chk("rst_busy",    {71'd0, busy}, 72'd0);
        chk("rst_done",    {71'd0, done}, 72'd0);
        chk("rst_err",     {71'd0, err}, 72'd0);
        chk("rst_err_idx", {69'd0, err_idx}, 72'd0);
        chk("rst_valids",  {69'd0, m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.arvalid}, 72'd0);
        chk("rst_readys",  {70'd0, m_axi_if.bready, m_axi_if.rready}, 72'd0);
        chk("rst_aw_w",    {4'd0, m_axi_if.awaddr, m_axi_if.wdata, m_axi_if.wstrb}, 72'd0);
        rstn = 1'b1;
        tick(2);

        // Three entries, verify off
        en = 8'b0000_0111; verify = 1'b0; log_q.delete(); dc0 = done_cnt;
        pulse_start();
        chk("t1_busy", {71'd0, busy}, 72'd1);
        wait_done(cyc);
        tick(1);
        chk("t1_after_busy", {71'd0, busy}, 72'd0);
        chk("t1_log_size", 72'(log_q.size()), 72'd3);
        chk("t1_wr0", log_q[0], mk(K_W, 32'h00, 32'h1000));
        chk("t1_wr1", log_q[1], mk(K_W, 32'h04, 32'h1FFF));
        chk("t1_wr2", log_q[2], mk(K_W, 32'h08, 32'h0001));
        chk("t1_done_once", 72'(done_cnt - dc0), 72'd1);
        chk("t1_err", {71'd0, err}, 72'd0);

        // Same table, verify on
        verify = 1'b1; log_q.delete();
        pulse_start();
        wait_done(cyc);
        tick(1);
        chk("t2_log_size", 72'(log_q.size()), 72'd6);
        chk("t2_0", log_q[0], mk(K_W, 32'h00, 32'h1000));
        chk("t2_1", log_q[1], mk(K_R, 32'h00, 32'h1000));
        chk("t2_2", log_q[2], mk(K_W, 32'h04, 32'h1FFF));
        chk("t2_3", log_q[3], mk(K_R, 32'h04, 32'h1FFF));
        chk("t2_4", log_q[4], mk(K_W, 32'h08, 32'h0001));
        chk("t2_5", log_q[5], mk(K_R, 32'h08, 32'h0001));
        chk("t2_err", {71'd0, err}, 72'd0);

        // Entry 1 reads back corrupted; entry 2 must never be written
        corrupt_addr = 32'h04; log_q.delete(); dc0 = done_cnt;
        pulse_start();
        wait_done(cyc);
        tick(1);
        corrupt_addr = 32'hFFFF_FFFF;
        chk("t3_log_size", 72'(log_q.size()), 72'd4);
        chk("t3_3", log_q[3], mk(K_R, 32'h04, 32'hDEAD_BEEF));
        chk("t3_err", {71'd0, err}, 72'd1);
        chk("t3_err_idx", {69'd0, err_idx}, 72'd1);
        chk("t3_done_once", 72'(done_cnt - dc0), 72'd1);
        tick(3);
        chk("t3_err_sticky", {71'd0, err}, 72'd1);

        // AW ready immediately, W three cycles later, then SLVERR on entry 0
        verify = 1'b0; aw_lat = 0; w_lat = 3; bresp_cfg = 2'b10; log_q.delete();
        pulse_start();
        chk("t4_err_cleared", {71'd0, err}, 72'd0);
        wait_awvalid();
        chk("t4_first", {38'd0, m_axi_if.wvalid, m_axi_if.awaddr, m_axi_if.wstrb}, {38'd0, 1'b1, 32'h0, 4'hF});
        tick(1);
        chk("t4_aw_drop", {70'd0, m_axi_if.awvalid, m_axi_if.wvalid}, 72'b01);
        chk("t4_wdata_a", {40'd0, m_axi_if.wdata}, 72'h1000);
        tick(1);
        chk("t4_w_hold", {39'd0, m_axi_if.wvalid, m_axi_if.wdata}, {39'd0, 1'b1, 32'h1000});
        wait_done(cyc);
        tick(1);
        chk("t4_err", {71'd0, err}, 72'd1);
        chk("t4_err_idx", {69'd0, err_idx}, 72'd0);
        chk("t4_log_size", 72'(log_q.size()), 72'd1);
        w_lat = 0; bresp_cfg = 2'b00;

        // Entries 0 and 7 only, second start while busy is ignored
        en = 8'b1000_0001; log_q.delete(); dc0 = done_cnt;
        pulse_start();
        tick(2);
        pulse_start();
        wait_done(cyc);
        tick(5);
        chk("t5_log_size", 72'(log_q.size()), 72'd2);
        chk("t5_wr0", log_q[0], mk(K_W, 32'h00, 32'h1000));
        chk("t5_wr7", log_q[1], mk(K_W, 32'h1C, 32'hCAFE_0007));
        chk("t5_done_once", 72'(done_cnt - dc0), 72'd1);
        chk("t5_idle", {71'd0, busy}, 72'd0);
        chk("t5_err", {71'd0, err}, 72'd0);

        // All entries disabled: done 1+N+1 = 10 cycles after start, no traffic
        en = 8'h00; log_q.delete();
        pulse_start();
        wait_done(cyc);
        chk("t6_latency", 72'(cyc + 1), 72'd10);
        chk("t6_no_traffic", 72'(log_q.size()), 72'd0);
        tick(1);

        // Reset while AW is pending
        en = 8'b0000_0001; aw_lat = 20; w_lat = 20; log_q.delete();
        pulse_start();
        wait_awvalid();
        rstn = 1'b0;
        #1;
        chk("t7_rst_valids", {70'd0, m_axi_if.awvalid, m_axi_if.wvalid}, 72'd0);
        chk("t7_rst_busy", {71'd0, busy}, 72'd0);
        @(negedge clk);
        rstn = 1'b1; aw_lat = 0; w_lat = 0;
        tick(2);
        en = 8'b0000_0011;
        pulse_start();
        wait_done(cyc);
        tick(1);
        chk("t7_log_size", 72'(log_q.size()), 72'd2);
        chk("t7_wr0", log_q[0], mk(K_W, 32'h00, 32'h1000));
        chk("t7_wr1", log_q[1], mk(K_W, 32'h04, 32'h1FFF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
